spine_link_rx_bridge: RTL and testbench
=======================================

// Module: spine_link_rx_bridge
// PURPOSE
//  Far-end receiver for one leaf-router spine output (spineX1_out_data/valid), which carries 16-bit flits
//  with valid only and no backpressure. Buffers flits in a FIFO and re-presents them to the spine switch
//  on a valid/ready link, with dest_addr taken from the flit header bits [15:10].
//  Overflow drops flits and counts them. One instance per spine link.
// PARAMETERS
//  DWIDTH  16  flit width; dest addr = flit[DWIDTH-1 -: AWIDTH]
//  AWIDTH   6  dest address width
//  DEPTH    8  FIFO entries; power of 2, >=2 (output register is extra storage)
// PORTS
//  clk                 in   1                     clock
//  reset               in   1                     synchronous, active-high
//  leaf_in_data        in   DWIDTH                flit from leaf router spine output
//  leaf_in_valid       in   1                     flit qualifier; no ready returned
//  sw_out_data         out  DWIDTH                flit toward spine switch
//  sw_out_dest_addr    out  AWIDTH                = sw_out_data[DWIDTH-1 -: AWIDTH], registered together
//  sw_out_valid        out  1                     output register holds a flit
//  sw_out_ready        in   1                     switch accepts when valid&ready
//  fifo_level          out  $clog2(DEPTH)+1       FIFO occupancy, excludes output register
//  flit_count          out  16                    flits accepted into FIFO, saturating
//  drop_count          out  16                    flits dropped on overflow, saturating
//  sw_out_parity       out  1                     only with SPINE_PARITY_EN
// BEHAVIOUR
//  - Reset (sync, high): all outputs 0; FIFO pointers and counters 0; contents are don't-care.
//    Asserting reset mid-operation discards buffered and in-flight flits; leaf_in_valid is ignored in reset cycles.
//  - Ingress: leaf_in_valid=1 at edge -> write when !full, or when full and a FIFO pop happens that same edge.
//    Otherwise the flit is dropped and drop_count increments (holds at 16'hFFFF).
//    Each accepted write increments flit_count (holds at 16'hFFFF).
//  - Output stage, FSM on sw_out_valid:
//    EMPTY: if FIFO not empty, pop the head into the output register -> FULL.
//    FULL, ready=0: data, dest_addr and valid held stable.
//    FULL, ready=1: transfer. If FIFO not empty, pop the next head into the register (stay FULL, no bubble).
//    Otherwise -> EMPTY.
//  - Latency: flit sampled at edge N (written to FIFO) -> sw_out_valid=1 after edge N+1 when the output stage is idle.
//    No write-to-output bypass.
//  - Throughput: 1 flit/clk sustained when sw_out_ready=1.
//  - fifo_level = writes - pops. Simultaneous write and pop leaves it unchanged. Range 0..DEPTH.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty use an extra wrap bit.
//  - A write into an empty FIFO is not visible to the pop logic until the next edge.
//  - Order is strictly preserved. Dropped flits never appear on the output.
// CONFIGURATION
//  SPINE_PARITY_EN defined:
//    sw_out_parity = ^sw_out_data (even parity), registered with the data, 0 in reset and when EMPTY.
//  SPINE_PARITY_EN undefined:
//    the sw_out_parity port is absent. Logic is otherwise identical.
// TESTING
//  1 Reset: after reset, all outputs 0, fifo_level=0, no sw_out_valid while leaf_in_valid=0.
//  2 Single flit 16'hA5C3, sw_out_ready=1: sw_out_valid after edge N+1, dest_addr=6'h29, flit_count=1,
//    one-cycle valid.
//  3 Backpressure: hold ready=0 and stream 9 flits (DEPTH=8): output holds flit0, fifo_level=8,
//    no drop. 10th flit -> drop_count=1. Release ready -> flits 0..8 in order, no bubbles.
//  4 Full plus simultaneous pop: fifo_level=8 and ready=1 at the same edge as a write -> accepted,
//    level stays 8, drop_count unchanged.
//  5 Reset mid-stream: assert reset with 5 flits buffered -> next cycle valid=0, level=0, counters 0,
//    and no old flit emitted after release.
//  6 Saturation and parity: force 65540 drops -> drop_count=16'hFFFF.
//    With SPINE_PARITY_EN, flit 16'h0001 -> sw_out_parity=1.

Source files
------------

// File: rtl/spine_link_rx_bridge_if.sv
// Spine link bundle: leaf-side flit input plus switch-side valid/ready output.
interface spine_link_rx_bridge_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 6
);
  logic [DWIDTH-1:0] leaf_in_data;
  logic              leaf_in_valid;
  logic [DWIDTH-1:0] sw_out_data;
  logic [AWIDTH-1:0] sw_out_dest_addr;
  logic              sw_out_valid;
  logic              sw_out_ready;

  modport slave (
    input  leaf_in_data,
    input  leaf_in_valid,
    input  sw_out_ready,
    output sw_out_data,
    output sw_out_dest_addr,
    output sw_out_valid
  );

  modport master (
    output leaf_in_data,
    output leaf_in_valid,
    output sw_out_ready,
    input  sw_out_data,
    input  sw_out_dest_addr,
    input  sw_out_valid
  );
endinterface

// File: rtl/spine_link_rx_bridge.sv
// Spine link receiver: FIFO plus output register toward the spine switch.
// Optional even-parity output enabled by defining SPINE_PARITY_EN.
module spine_link_rx_bridge #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 6,
  parameter int DEPTH  = 8,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  spine_link_rx_bridge_if.slave   link,
  output logic [PW:0]             fifo_level,
  output logic [15:0]             flit_count,
  output logic [15:0]             drop_count
`ifdef SPINE_PARITY_EN
  ,
  output logic                    sw_out_parity
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]       wr_ptr_q, rd_ptr_q;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [15:0]       flit_q, drop_q;
  logic              empty, full;
  logic              pop, wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW])
              && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  // A pop on this edge frees a slot for the incoming flit.
  assign wr_en = link.leaf_in_valid && (!full || pop);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (link.sw_out_ready) begin
          if (!empty) pop = 1'b1;
          else        state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (pop) data_d = mem_q[rd_ptr_q[PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset)
      mem_q[wr_ptr_q[PW-1:0]] <= link.leaf_in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_EMPTY;
      data_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      flit_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wr_en && flit_q != 16'hFFFF)
        flit_q <= flit_q + 16'd1;
      if (link.leaf_in_valid && !wr_en && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end
  end

`ifdef SPINE_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (reset)                   par_q <= 1'b0;
    else if (pop)                par_q <= ^data_d;
    else if (state_d == S_EMPTY) par_q <= 1'b0;
  end

  assign sw_out_parity = par_q;
`endif

  assign link.sw_out_data      = data_q;
  assign link.sw_out_dest_addr = data_q[DWIDTH-1 -: AWIDTH];
  assign link.sw_out_valid     = (state_q == S_FULL);
  assign fifo_level            = wr_ptr_q - rd_ptr_q;
  assign flit_count            = flit_q;
  assign drop_count            = drop_q;

endmodule

// File: tb/tb_spine_link_rx_bridge.sv
// Bench for spine_link_rx_bridge: vector table, scoreboard model and corner sequences.
// Define SPINE_PARITY_EN to also exercise sw_out_parity.
module tb_spine_link_rx_bridge;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  fifo_level;
  logic [15:0] flit_count;
  logic [15:0] drop_count;
`ifdef SPINE_PARITY_EN
  logic        sw_out_parity;
`endif

  spine_link_rx_bridge_if #(.DWIDTH(16), .AWIDTH(6)) bus ();

  spine_link_rx_bridge #(
    .DWIDTH(16), .AWIDTH(6), .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .link      (bus.slave),
    .fifo_level(fifo_level),
    .flit_count(flit_count),
    .drop_count(drop_count)
`ifdef SPINE_PARITY_EN
    ,
    .sw_out_parity(sw_out_parity)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [15:0] sb [$];
  bit          m_ov;
  int          m_fl, m_dr;

  typedef struct {
    logic        vin;
    logic [15:0] din;
    logic        rdy;
    logic        ev;
    logic [3:0]  el;
    logic [15:0] efc;
    logic [5:0]  ed;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    int lvl;
    lvl = sb.size() - (m_ov ? 1 : 0);
    chk("valid", 32'(bus.sw_out_valid), 32'(m_ov));
    chk("level", 32'(fifo_level), 32'(lvl));
    chk("flits", 32'(flit_count), 32'(m_fl));
    chk("drops", 32'(drop_count), 32'(m_dr));
    if (m_ov) begin
      chk("data", 32'(bus.sw_out_data), 32'(sb[0]));
      chk("dest", 32'(bus.sw_out_dest_addr), 32'(sb[0][15:10]));
    end
`ifdef SPINE_PARITY_EN
    chk("parity", 32'(sw_out_parity), m_ov ? 32'(^sb[0]) : 32'd0);
`endif
  endtask

  task automatic step(input logic vin, input logic [15:0] din,
                      input logic rdy, input logic rst);
    int  lvl;
    bit  xfer, pop, acc;
    bus.leaf_in_valid = vin;
    bus.leaf_in_data  = din;
    bus.sw_out_ready  = rdy;
    reset             = rst;
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      m_ov = 1'b0;
      m_fl = 0;
      m_dr = 0;
    end else begin
      lvl  = sb.size() - (m_ov ? 1 : 0);
      xfer = m_ov && rdy;
      pop  = (lvl > 0) && (!m_ov || rdy);
      acc  = vin && ((lvl < DEPTH) || pop);
      if (xfer) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(din);
        if (m_fl < 16'hFFFF) m_fl++;
      end else if (vin && m_dr < 16'hFFFF) begin
        m_dr++;
      end
      if (pop)       m_ov = 1'b1;
      else if (xfer) m_ov = 1'b0;
    end
    check_model();
  endtask

  initial begin
    logic [15:0] f [10];
    tbl[0] = '{1'b1, 16'hA5C3, 1'b1, 1'b0, 4'd1, 16'd1, 6'h00};
    tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 16'd1, 6'h29};
    tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'd1, 6'h00};
    tbl[3] = '{1'b1, 16'h1234, 1'b1, 1'b0, 4'd1, 16'd2, 6'h00};
    tbl[4] = '{1'b1, 16'hFC00, 1'b1, 1'b1, 4'd1, 16'd3, 6'h04};
    tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 4'd0, 16'd3, 6'h3F};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 16'd3, 6'h00};
    for (int i = 0; i < 10; i++) f[i] = 16'(i * 16'h0C11 + 16'h0101);

    bus.leaf_in_valid = 1'b0;
    bus.leaf_in_data  = '0;
    bus.sw_out_ready  = 1'b0;

    // Reset state and idle behaviour.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 16'hFFFF, 1'b1, 1'b1);
    chk("rst_valid", 32'(bus.sw_out_valid), 32'd0);
    chk("rst_data", 32'(bus.sw_out_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_flits", 32'(flit_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("idle_valid", 32'(bus.sw_out_valid), 32'd0);
    end

    // Vector table: single flit latency, then back-to-back flits.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].vin, tbl[i].din, tbl[i].rdy, 1'b0);
      chk("tbl_valid", 32'(bus.sw_out_valid), 32'(tbl[i].ev));
      chk("tbl_level", 32'(fifo_level), 32'(tbl[i].el));
      chk("tbl_flits", 32'(flit_count), 32'(tbl[i].efc));
      if (tbl[i].ev)
        chk("tbl_dest", 32'(bus.sw_out_dest_addr), 32'(tbl[i].ed));
    end

    // Backpressure fill, overflow drop, release with no bubbles.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, f[i], 1'b0, 1'b0);
    chk("bp_level", 32'(fifo_level), 32'd8);
    chk("bp_drops", 32'(drop_count), 32'd0);
    chk("bp_head", 32'(bus.sw_out_data), 32'(f[0]));
    step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    chk("ovf_drops", 32'(drop_count), 32'd1);
    chk("ovf_level", 32'(fifo_level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("nobubble_v", 32'(bus.sw_out_valid), 32'd1);
      chk("order", 32'(bus.sw_out_data), 32'(f[i+1]));
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("drained", 32'(bus.sw_out_valid), 32'd0);

    // Write into a full FIFO on the same edge as a pop.
    for (int i = 0; i < 9; i++) step(1'b1, f[9-i], 1'b0, 1'b0);
    chk("full_level", 32'(fifo_level), 32'd8);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("fullpop_level", 32'(fifo_level), 32'd8);
    chk("fullpop_drops", 32'(drop_count), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("fullpop_empty", 32'(sb.size()), 32'd0);

    // Reset with flits buffered.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, f[i], 1'b0, 1'b0);
    step(1'b1, 16'h7777, 1'b0, 1'b1);
    chk("mid_valid", 32'(bus.sw_out_valid), 32'd0);
    chk("mid_level", 32'(fifo_level), 32'd0);
    chk("mid_flits", 32'(flit_count), 32'd0);
    chk("mid_drops", 32'(drop_count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("mid_noold", 32'(bus.sw_out_valid), 32'd0);
    end

    // Parity on a single-bit flit, then drop-counter saturation.
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 16'h0001, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("par_valid", 32'(bus.sw_out_valid), 32'd1);
`ifdef SPINE_PARITY_EN
    chk("par_bit", 32'(sw_out_parity), 32'd1);
`endif
    for (int i = 0; i < 8; i++) step(1'b1, f[i], 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    chk("sat_drops", 32'(drop_count), 32'h0000FFFF);
    chk("sat_flits", 32'(flit_count), 32'd9);
    chk("sat_level", 32'(fifo_level), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
